// File: rtl/imm_gen_if.sv
// Valid/ready bus between decode, the immediate generator and the ALU/branch unit.
//   in_valid/in_ready/in_instr/in_tag     : instruction side
//   out_valid/out_ready/out_imm/out_fmt,
//   out_illegal/out_tag                   : result side
// slave is the generator's view, master is the view of the surrounding logic.
interface imm_gen_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator for RV32/RV64 decode.
// Stage 1 captures the instruction, tag and decoded format; stage 2 holds the
// sign-extended immediate, format, illegal flag and tag.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   flush      : synchronous kill of both stages
//   bus        : imm_gen_if.slave, instruction in / result out handshake
//   ill_count  : saturating count of illegal results handed off
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    imm_gen_if.slave    bus,
    output logic [15:0] ill_count
);
    localparam int unsigned FMT_W   = 3;
    localparam int unsigned INSTR_W = 32;
    localparam bit          RV64    = (XLEN == 64);

    localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
    localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic                s1_valid;
    logic [INSTR_W-1:0]  s1_instr;
    logic [TAG_W-1:0]    s1_tag;
    logic [FMT_W-1:0]    s1_fmt;

    logic                s2_valid;
    logic [XLEN-1:0]     s2_imm;
    logic [FMT_W-1:0]    s2_fmt;
    logic                s2_illegal;
    logic [TAG_W-1:0]    s2_tag;

    logic                s2_adv_c;
    logic                s1_adv_c;
    logic                in_fire_c;
    logic                out_fire_c;
    logic [FMT_W-1:0]    dec_fmt_c;
    logic [INSTR_W-1:0]  imm32_c;
    logic [XLEN-1:0]     imm_ext_c;

    // Handshake: a stage moves when it is empty or its consumer takes the entry.
    assign s2_adv_c   = !s2_valid || bus.out_ready;
    assign s1_adv_c   = !s1_valid || s2_adv_c;
    assign in_fire_c  = bus.in_valid && s1_adv_c;
    assign out_fire_c = s2_valid && bus.out_ready;

    assign bus.in_ready    = s1_adv_c;
    assign bus.out_valid   = s2_valid;
    assign bus.out_imm     = s2_imm;
    assign bus.out_fmt     = s2_fmt;
    assign bus.out_illegal = s2_illegal;
    assign bus.out_tag     = s2_tag;

    // Opcode to format; the W-suffixed opcodes exist only on RV64.
    always_comb begin
        dec_fmt_c = FMT_ILL;
        case (bus.in_instr[6:0])
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: dec_fmt_c = FMT_I;
            7'b0011011: dec_fmt_c = RV64 ? FMT_I : FMT_ILL;
            7'b0100011: dec_fmt_c = FMT_S;
            7'b1100011: dec_fmt_c = FMT_B;
            7'b0110111,
            7'b0010111: dec_fmt_c = FMT_U;
            7'b1101111: dec_fmt_c = FMT_J;
            7'b0110011: dec_fmt_c = FMT_R;
            7'b0111011: dec_fmt_c = RV64 ? FMT_R : FMT_ILL;
            default:    dec_fmt_c = FMT_ILL;
        endcase
    end

    // Immediate assembled as a 32-bit signed value, then widened to XLEN.
    always_comb begin
        imm32_c = '0;
        case (s1_fmt)
            FMT_I: imm32_c = {{20{s1_instr[31]}}, s1_instr[31:20]};
            FMT_S: imm32_c = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
            FMT_B: imm32_c = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                              s1_instr[30:25], s1_instr[11:8], 1'b0};
            FMT_U: imm32_c = {s1_instr[31:12], 12'b0};
            FMT_J: imm32_c = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                              s1_instr[20], s1_instr[30:21], 1'b0};
            default: imm32_c = '0;
        endcase
    end

    assign imm_ext_c = XLEN'($signed(imm32_c));

    // Stage 1: instruction, tag and decoded format.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_tag   <= '0;
            s1_fmt   <= FMT_R;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv_c) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire_c) begin
                s1_instr <= bus.in_instr;
                s1_tag   <= bus.in_tag;
                s1_fmt   <= dec_fmt_c;
            end
        end
    end

    // Stage 2: result registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_imm     <= '0;
            s2_fmt     <= FMT_R;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv_c) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv_c && s1_valid) begin
                s2_imm     <= imm_ext_c;
                s2_fmt     <= s1_fmt;
                s2_illegal <= (s1_fmt == FMT_ILL);
                s2_tag     <= s1_tag;
            end
        end
    end

    // Illegal results handed off, saturating; flush does not affect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_count <= '0;
        end else if (out_fire_c && s2_illegal && (ill_count != 16'hFFFF)) begin
            ill_count <= ill_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush32 = 1'b0;
    logic        flush64 = 1'b0;
    logic [15:0] ill32;
    logic [15:0] ill64;

    int errors = 0;
    int checks = 0;
    int exp_ill = 0;
    exp_t q32[$];
    exp_t q64[$];

    imm_gen_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32.slave), .ill_count(ill32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64.slave), .ill_count(ill64));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] i, input bit rv64, input logic [4:0] tag);
        exp_t e;
        logic s;
        s = i[31];
        e.tag = tag;
        e.imm = '0;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.fmt = 3'd1;
            7'b0011011: e.fmt = rv64 ? 3'd1 : 3'd7;
            7'b0100011: e.fmt = 3'd2;
            7'b1100011: e.fmt = 3'd3;
            7'b0110111, 7'b0010111: e.fmt = 3'd4;
            7'b1101111: e.fmt = 3'd5;
            7'b0110011: e.fmt = 3'd0;
            7'b0111011: e.fmt = rv64 ? 3'd0 : 3'd7;
            default: e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: e.imm = {{52{s}}, i[31:20]};
            3'd2: e.imm = {{52{s}}, i[31:25], i[11:7]};
            3'd3: e.imm = {{51{s}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: e.imm = {{32{s}}, i[31:12], 12'b0};
            3'd5: e.imm = {{43{s}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic [4:0] tag);
        exp_t e;
        e.imm = imm;
        e.fmt = fmt;
        e.tag = tag;
        return e;
    endfunction

    task automatic idle_all();
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        flush32 = 1'b0; flush64 = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_imm !== 32'h0 || b32.out_fmt !== 3'd0 ||
            b32.out_illegal !== 1'b0 || b32.out_tag !== 5'd0 || ill32 !== 16'h0) begin
            errors++;
            $display("FAIL reset32 got v=%b imm=%h fmt=%0d ill=%b tag=%0d cnt=%0d expected all zero",
                     b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag, ill32);
        end
        checks++;
        if (b64.out_valid !== 1'b0 || b64.out_imm !== 64'h0 || ill64 !== 16'h0) begin
            errors++;
            $display("FAIL reset64 got v=%b imm=%h cnt=%0d expected all zero", b64.out_valid, b64.out_imm, ill64);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b expected 1/1", b32.in_ready, b64.in_ready);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        b32.in_valid = 1'b1; b32.in_instr = 32'hFE000EE3; b32.in_tag = 5'd7;
        q32.push_back(mk(64'hFFFFFFFC, 3'd3, 5'd7));
        @(negedge clk);
        b32.in_valid = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_lat1 got out_valid=%b expected 0", b32.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFFC || b32.out_fmt !== 3'd3 ||
            b32.out_illegal !== 1'b0 || b32.out_tag !== 5'd7) begin
            errors++;
            $display("FAIL branch_out got v=%b imm=%h fmt=%0d ill=%b tag=%0d expected v=1 imm=fffffffc fmt=3 ill=0 tag=7",
                     b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag);
        end
        void'(q32.pop_front());
        @(negedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_drop got out_valid=%b expected 0", b32.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4] = '{32'hFFF00093, 32'hFE20AC23, 32'h123450B7, 32'h0080006F};
        logic [31:0] imm [4] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'h12345000, 32'h00000008};
        logic [2:0]  fmt [4] = '{3'd1, 3'd2, 3'd4, 3'd5};
        int pops = 0;
        exp_t e;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            b32.in_valid = (n < 4);
            b32.in_instr = (n < 4) ? ins[n] : 32'h0;
            b32.in_tag   = 5'(10 + n);
            #1;
            if (n < 4) begin
                checks++;
                if (b32.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready cycle=%0d got %b expected 1", n, b32.in_ready);
                end
                q32.push_back(mk({32'h0, imm[n]}, fmt[n], 5'(10 + n)));
            end
            if (b32.out_valid) begin
                checks++;
                if (q32.size() == 0 || n != 2 + pops) begin
                    errors++;
                    $display("FAIL b2b_timing got output at cycle %0d expected cycle %0d", n, 2 + pops);
                end else begin
                    e = q32.pop_front();
                    checks++;
                    if (b32.out_imm !== e.imm[31:0] || b32.out_fmt !== e.fmt || b32.out_tag !== e.tag ||
                        b32.out_illegal !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_out got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                                 b32.out_imm, b32.out_fmt, b32.out_tag, e.imm[31:0], e.fmt, e.tag);
                    end
                end
                pops++;
            end
        end
        checks++;
        if (pops != 4 || q32.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d outputs expected 4", pops);
        end
        q32.delete();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'h00000000; b32.in_tag = 5'd3;
        @(negedge clk);
        b32.in_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (n == 1) b32.out_ready = 1'b1;
            #1;
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_fmt !== 3'd7 || b32.out_illegal !== 1'b1 ||
                b32.out_imm !== 32'h0 || b32.out_tag !== 5'd3 || ill32 !== 16'd0) begin
                errors++;
                $display("FAIL illegal_out got v=%b fmt=%0d ill=%b imm=%h tag=%0d cnt=%0d expected v=1 fmt=7 ill=1 imm=0 tag=3 cnt=0",
                         b32.out_valid, b32.out_fmt, b32.out_illegal, b32.out_imm, b32.out_tag, ill32);
            end
        end
        exp_ill++;
        @(negedge clk);
        #1;
        checks++;
        if (ill32 !== 16'd1 || b32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_count got cnt=%0d v=%b expected cnt=1 v=0", ill32, b32.out_valid);
        end
    endtask

    task automatic test_rv64();
        logic [31:0] ins  [5] = '{32'h800000B7, 32'hFFF00093, 32'h0010009B, 32'h0000003B, 32'hFE000EE3};
        logic [63:0] im64 [5] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 64'hFFFFFFFFFFFFFFFC};
        logic [2:0]  f64  [5] = '{3'd4, 3'd1, 3'd1, 3'd0, 3'd3};
        logic [31:0] im32 [5] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFC};
        logic [2:0]  f32  [5] = '{3'd4, 3'd1, 3'd7, 3'd7, 3'd3};
        exp_t e;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            b32.in_valid = (n < 5); b64.in_valid = (n < 5);
            b32.in_instr = (n < 5) ? ins[n] : 32'h0; b64.in_instr = b32.in_instr;
            b32.in_tag = 5'(n); b64.in_tag = 5'(n);
            #1;
            if (n < 5) begin
                q32.push_back(mk({32'h0, im32[n]}, f32[n], 5'(n)));
                q64.push_back(mk(im64[n], f64[n], 5'(n)));
            end
            if (b64.out_valid && q64.size() != 0) begin
                e = q64.pop_front();
                checks++;
                if (b64.out_imm !== e.imm || b64.out_fmt !== e.fmt || b64.out_tag !== e.tag ||
                    b64.out_illegal !== (e.fmt == 3'd7)) begin
                    errors++;
                    $display("FAIL rv64_out got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                             b64.out_imm, b64.out_fmt, b64.out_tag, e.imm, e.fmt, e.tag);
                end
            end
            if (b32.out_valid && q32.size() != 0) begin
                e = q32.pop_front();
                checks++;
                if (b32.out_imm !== e.imm[31:0] || b32.out_fmt !== e.fmt || b32.out_tag !== e.tag ||
                    b32.out_illegal !== (e.fmt == 3'd7)) begin
                    errors++;
                    $display("FAIL rv32_w_out got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                             b32.out_imm, b32.out_fmt, b32.out_tag, e.imm[31:0], e.fmt, e.tag);
                end
                if (e.fmt == 3'd7) exp_ill++;
            end
        end
        checks++;
        if (q32.size() != 0 || q64.size() != 0 || ill32 !== 16'(exp_ill) || ill64 !== 16'd0) begin
            errors++;
            $display("FAIL rv64_drain got left=%0d/%0d cnt32=%0d cnt64=%0d expected 0/0 %0d 0",
                     q32.size(), q64.size(), ill32, ill64, exp_ill);
        end
        q32.delete(); q64.delete();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int pops = 0;
        exp_t e;
        b32.out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            b32.in_valid = 1'b1;
            b32.in_instr = {12'(idx + 1), 20'h00093};
            b32.in_tag = 5'(idx + 1);
            #1;
            if (b32.in_ready) begin
                q32.push_back(mk(64'(idx + 1), 3'd1, 5'(idx + 1)));
                idx++;
            end
            if (b32.out_valid) begin
                checks++;
                if (b32.out_tag !== 5'd1 || b32.out_imm !== 32'd1) begin
                    errors++;
                    $display("FAIL bp_hold got tag=%0d imm=%h expected tag=1 imm=00000001", b32.out_tag, b32.out_imm);
                end
            end
        end
        checks++;
        if (idx != 2 || b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got accepts=%0d in_ready=%b out_valid=%b expected 2 0 1", idx, b32.in_ready, b32.out_valid);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            b32.out_ready = 1'b1;
            b32.in_valid = (idx < 3);
            b32.in_instr = {12'(idx + 1), 20'h00093};
            b32.in_tag = 5'(idx + 1);
            #1;
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(mk(64'(idx + 1), 3'd1, 5'(idx + 1)));
                idx++;
            end
            if (b32.out_valid) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra got tag=%0d expected no output", b32.out_tag);
                end else begin
                    e = q32.pop_front();
                    if (b32.out_tag !== e.tag || b32.out_imm !== e.imm[31:0]) begin
                        errors++;
                        $display("FAIL bp_order got tag=%0d imm=%h expected tag=%0d imm=%h",
                                 b32.out_tag, b32.out_imm, e.tag, e.imm[31:0]);
                    end
                    pops++;
                end
            end
        end
        checks++;
        if (pops != 3 || q32.size() != 0) begin
            errors++;
            $display("FAIL bp_count got %0d outputs expected 3", pops);
        end
        q32.delete();
    endtask

    task automatic test_flush();
        int idx = 0;
        int extra = 0;
        exp_t e;
        b32.out_ready = 1'b0;
        for (int n = 0; n < 6 && idx < 2; n++) begin
            @(negedge clk);
            b32.in_valid = 1'b1;
            b32.in_instr = (idx == 0) ? 32'h00000000 : 32'h00500093;
            b32.in_tag = 5'(20 + idx);
            #1;
            if (b32.in_ready) begin
                q32.push_back((idx == 0) ? mk(64'h0, 3'd7, 5'd20) : mk(64'h5, 3'd1, 5'd21));
                idx++;
            end
        end
        @(negedge clk);
        flush32 = 1'b1; b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.in_instr = 32'h00700093; b32.in_tag = 5'd22;
        #1;
        e = q32.pop_front();
        checks++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b1 || b32.out_tag !== e.tag || b32.out_fmt !== e.fmt) begin
            errors++;
            $display("FAIL flush_cycle got in_ready=%b v=%b tag=%0d fmt=%0d expected 1 1 %0d %0d",
                     b32.in_ready, b32.out_valid, b32.out_tag, b32.out_fmt, e.tag, e.fmt);
        end
        exp_ill++;
        q32.delete();
        @(negedge clk);
        flush32 = 1'b0; b32.in_valid = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || ill32 !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL flush_kill got v=%b cnt=%0d expected v=0 cnt=%0d", b32.out_valid, ill32, exp_ill);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            if (b32.out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL flush_ghost got %0d outputs expected 0", extra);
        end
    endtask

    task automatic test_saturate();
        int tail = 0;
        b32.out_ready = 1'b1;
        for (int n = 0; n < 70000 && tail < 6; n++) begin
            @(negedge clk);
            b32.in_valid = (exp_ill < 65535) || (tail < 3);
            b32.in_instr = 32'h00000000; b32.in_tag = 5'd9;
            #1;
            if (exp_ill >= 65533) begin
                checks++;
                if (ill32 !== 16'(exp_ill)) begin
                    errors++;
                    $display("FAIL sat_count got %0d expected %0d", ill32, exp_ill);
                end
            end
            if (b32.out_valid && b32.out_ready && exp_ill < 65535) exp_ill++;
            if (exp_ill == 65535) tail++;
        end
        checks++;
        if (ill32 !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_final got %h expected ffff", ill32);
        end
        b32.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b32.out_ready = 1'b0; b64.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'hFFF00093; b32.in_tag = 5'd5;
        b64.in_valid = 1'b1; b64.in_instr = 32'hFFF00093; b64.in_tag = 5'd5;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_imm !== 32'h0 || b32.out_fmt !== 3'd0 ||
            b32.out_illegal !== 1'b0 || b32.out_tag !== 5'd0 || ill32 !== 16'h0 ||
            b64.out_valid !== 1'b0 || b64.out_imm !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid got v=%b imm=%h fmt=%0d tag=%0d cnt=%0d v64=%b expected all zero",
                     b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_tag, ill32, b64.out_valid);
        end
        idle_all();
        exp_ill = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        logic [31:0] r;
        exp_t e;
        for (int n = 0; n < 420; n++) begin
            @(negedge clk);
            if (n < 400) begin
                r = $urandom();
                b32.in_valid = ($urandom_range(3) != 0);
                b32.in_instr = {r[31:7], ($urandom_range(7) == 0) ? r[6:0] : ops[$urandom_range(11)]};
                b32.in_tag = 5'(n);
                b32.out_ready = ($urandom_range(9) < 7);
                r = $urandom();
                b64.in_valid = ($urandom_range(3) != 0);
                b64.in_instr = {r[31:7], ($urandom_range(7) == 0) ? r[6:0] : ops[$urandom_range(11)]};
                b64.in_tag = 5'(n);
                b64.out_ready = ($urandom_range(9) < 7);
            end else begin
                idle_all();
            end
            #1;
            if (b32.in_valid && b32.in_ready) q32.push_back(model(b32.in_instr, 1'b0, b32.in_tag));
            if (b64.in_valid && b64.in_ready) q64.push_back(model(b64.in_instr, 1'b1, b64.in_tag));
            if (b32.out_valid && b32.out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL rand32_extra got tag=%0d expected no output", b32.out_tag);
                end else begin
                    e = q32.pop_front();
                    if (b32.out_imm !== e.imm[31:0] || b32.out_fmt !== e.fmt || b32.out_tag !== e.tag ||
                        b32.out_illegal !== (e.fmt == 3'd7)) begin
                        errors++;
                        $display("FAIL rand32_out got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                                 b32.out_imm, b32.out_fmt, b32.out_tag, e.imm[31:0], e.fmt, e.tag);
                    end
                    if (e.fmt == 3'd7) exp_ill++;
                end
            end
            if (b64.out_valid && b64.out_ready) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL rand64_extra got tag=%0d expected no output", b64.out_tag);
                end else begin
                    e = q64.pop_front();
                    if (b64.out_imm !== e.imm || b64.out_fmt !== e.fmt || b64.out_tag !== e.tag ||
                        b64.out_illegal !== (e.fmt == 3'd7)) begin
                        errors++;
                        $display("FAIL rand64_out got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                                 b64.out_imm, b64.out_fmt, b64.out_tag, e.imm, e.fmt, e.tag);
                    end
                end
            end
        end
        checks++;
        if (q32.size() != 0 || q64.size() != 0 || ill32 !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL rand_drain got left=%0d/%0d cnt=%0d expected 0/0 cnt=%0d",
                     q32.size(), q64.size(), ill32, exp_ill);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_rv64();
        test_backpressure();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV32/RV64 decode path.
- Decodes the instruction format from the opcode and produces the sign-extended XLEN-bit immediate for all base formats: I, S, B, U and J.
- Sits between fetch/decode and the ALU/branch unit behind a valid/ready handshake, with flush support and an illegal-opcode counter.

Parameters:
- XLEN, 32, immediate output width; only 32 or 64 are legal.
- TAG_W, 5, width of the sideband tag carried with each instruction (e.g. rd or ROB index).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  block can accept an instruction.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- flush  input  1  synchronous pipeline kill.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- out_illegal  output  1  high when out_fmt is 7.
- out_tag  output  TAG_W  tag delivered with the result.
- ill_count  output  16  saturating count of illegal results handed off.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids, out_imm, out_fmt, out_illegal, out_tag and ill_count go to 0. in_ready is 1 once reset is released.
- Stage 1 registers instr, tag and the decoded format. Stage 2 registers out_imm, out_fmt, out_illegal and out_tag.
- Latency: 2 cycles from the input handshake to out_valid, when out_ready is held high.
- Throughput: one instruction per cycle.
- Format decode from instr[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011; also 0011011 when XLEN==64 (illegal when XLEN==32).
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011, plus 0111011 when XLEN==64. R produces imm 0 and is not illegal.
  - Anything else is illegal: imm 0, out_fmt 7.
- Immediate assembly, all sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}, which is sign-extended above bit 31 when XLEN==64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Shift-immediate funct7/shamt bits are not special-cased; the raw I immediate is produced.
- Handshake:
  - An input transfer happens when in_valid && in_ready; an output transfer when out_valid && out_ready.
  - Stage 2 advances when it is empty or out_ready is high. Stage 1 advances when it is empty or stage 2 advances.
  - in_ready = !s1_valid || s2_advance. This is a combinational path from out_ready; 2 entries of buffering in total.
  - While out_valid && !out_ready: out_imm, out_fmt, out_illegal and out_tag hold stable, and out_valid stays high.
  - in_valid may drop without a transfer. Ordering is strictly FIFO.
- Flush (sampled at the clock edge):
  - Both stage valids clear on the next edge.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle completes normally and is counted.
  - in_ready stays as computed during the flush cycle. Data registers need not clear.
- ill_count:
  - Increments by 1 on each output transfer with out_illegal=1.
  - Saturates at 0xFFFF and is cleared only by reset.
- Simultaneous input and output transfer with both stages full: the pipeline shifts, occupancy is unchanged.
- Reset mid-operation: all in-flight instructions are lost; out_valid drops immediately (asynchronously).

Test Plan:
- XLEN=32, out_ready=1, in_instr=0xFE000EE3 (beq x0,x0,-4) -> 2 cycles later out_valid=1, out_imm=0xFFFFFFFC, out_fmt=3, out_illegal=0.
- Back-to-back, one per cycle:
  - 0xFFF00093 -> 0xFFFFFFFF, fmt 1.
  - 0xFE20AC23 -> 0xFFFFFFF8, fmt 2.
  - 0x123450B7 -> 0x12345000, fmt 4.
  - 0x0080006F -> 0x00000008, fmt 5.
  - Results arrive on consecutive cycles, in order, with tags matching.
- XLEN=64:
  - 0x800000B7 -> 0xFFFFFFFF80000000.
  - 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - 0x0010009B (addiw) -> 0x1, fmt 1; the same word at XLEN=32 -> fmt 7.
- Illegal: 0x00000000 -> out_fmt=7, out_illegal=1, out_imm=0, ill_count 0->1 on handshake. Preload the counter with 0xFFFF illegal transfers -> it stays 0xFFFF.
- Backpressure:
  - out_ready=0 for 6 cycles while in_valid=1 with tags 1,2,3 -> in_ready falls after 2 accepts and out_imm/out_tag hold stable.
  - Release out_ready -> tags 1,2,3 emerge in order, no loss or duplication.
- Flush and reset:
  - flush with 2 entries in flight plus an input transfer the same cycle -> next cycle out_valid=0, and none of the 3 entries appear.
  - rst_n low mid-stream -> all outputs and ill_count read 0 at once.
